fft_twiddle_addr_gen: RTL

FFT_TWIDDLE_ADDR_GEN -- requirements
Module: fft_twiddle_addr_gen

---
 rtl/fft_twiddle_addr_gen.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fft_twiddle_addr_gen.sv
// Twiddle-factor address generator for an in-place radix-2 FFT (DIT or DIF ordering).
// Optional quarter-wave table folding is enabled by defining TWIDDLE_QUARTER_EN.
module fft_twiddle_addr_gen #(
    parameter int LOG_N = 10,
    parameter int LANES = 1,
    localparam int AW = LOG_N - 1,
    localparam int SW = $clog2(LOG_N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                dif,
    input  logic                inverse,
    input  logic                abort,
    input  logic                w_ready,
    output logic                w_valid,
    output logic [LANES*AW-1:0] w_addr,
    output logic [LANES-1:0]    w_negre,
    output logic                w_conj,
    output logic [SW-1:0]       stage,
    output logic                last_in_stage,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [SW-1:0] LAST_STAGE = SW'(AW);
    localparam logic [AW-1:0] K_STEP     = AW'(LANES);
    // N/2 == 2^AW, so N/2 - LANES is simply -LANES modulo 2^AW
    localparam logic [AW-1:0] K_LAST     = AW'(0) - K_STEP;

    state_t            state_q, state_d;
    logic [AW-1:0]     k_q, k_d;
    logic [SW-1:0]     stage_d;
    logic              dif_q, dif_d;
    logic              conj_d;
    logic              valid_d;
    logic              busy_d;
    logic              done_d;
    logic              last_d;
    logic              load;
    logic [LANES*AW-1:0] addr_d;
    logic [AW-1:0]     lane_e;

    function automatic logic [AW-1:0] lane_exp(input logic [SW-1:0] s,
                                               input logic [AW-1:0] k,
                                               input logic          d);
        logic [AW-1:0] ones;
        ones = '1;
        if (d)
            return (k & ~(ones << (LAST_STAGE - s))) << s;
        else
            return (k & ~(ones << s)) << (LAST_STAGE - s);
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage;
        dif_d   = dif_q;
        conj_d  = w_conj;
        valid_d = w_valid;
        busy_d  = busy;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    stage_d = '0;
                    dif_d   = dif;
                    conj_d  = inverse;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (w_ready) begin
                    if (k_q == K_LAST) begin
                        if (stage == LAST_STAGE) begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            stage_d = stage + 1'b1;
                            k_d     = '0;
                            load    = 1'b1;
                        end
                    end else begin
                        k_d  = k_q + K_STEP;
                        load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Beat outputs are computed from the next counter values so they can be registered.
`ifdef TWIDDLE_QUARTER_EN
    localparam logic [AW-1:0] QTR = AW'(1) << (AW - 1);
    logic [LANES-1:0] negre_d;

    always_comb begin
        addr_d  = w_addr;
        negre_d = w_negre;
        last_d  = last_in_stage;
        lane_e  = '0;
        if (load) begin
            last_d = (k_d == K_LAST);
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_e = lane_exp(stage_d, k_d + AW'(i), dif_d);
                if (lane_e > QTR) begin
                    addr_d[i*AW +: AW] = AW'(0) - lane_e;
                    negre_d[i]         = 1'b1;
                end else begin
                    addr_d[i*AW +: AW] = lane_e;
                    negre_d[i]         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            w_negre <= '0;
        else
            w_negre <= negre_d;
    end
`else
    always_comb begin
        addr_d = w_addr;
        last_d = last_in_stage;
        lane_e = '0;
        if (load) begin
            last_d = (k_d == K_LAST);
            for (int unsigned i = 0; i < LANES; i++) begin
                lane_e             = lane_exp(stage_d, k_d + AW'(i), dif_d);
                addr_d[i*AW +: AW] = lane_e;
            end
        end
    end

    assign w_negre = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            stage         <= '0;
            dif_q         <= 1'b0;
            w_conj        <= 1'b0;
            w_valid       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            w_addr        <= '0;
            last_in_stage <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            stage         <= stage_d;
            dif_q         <= dif_d;
            w_conj        <= conj_d;
            w_valid       <= valid_d;
            busy          <= busy_d;
            done          <= done_d;
            w_addr        <= addr_d;
            last_in_stage <= last_d;
        end
    end

endmodule
